// File: rtl/d_flip_flop_pkg.sv
// d_flip_flop_pkg: shared defaults and legal limits for the d_flip_flop
// register pipeline.
//   DFF_WDT_DEF / DFF_WDT_MAX       : default and maximum data width
//   DFF_RST_VAL_DEF                 : default reset value of every stage
//   DFF_STAGES_DEF / DFF_STAGES_MAX : default and maximum pipeline depth
package d_flip_flop_pkg;

  localparam int DFF_WDT_DEF     = 1;
  localparam int DFF_WDT_MAX     = 1024;
  localparam int DFF_RST_VAL_DEF = 0;
  localparam int DFF_STAGES_DEF  = 1;
  localparam int DFF_STAGES_MAX  = 16;

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop_stage.sv
// d_ff_stage: one WDT-wide register stage with asynchronous active-low reset.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, forces q to RST_VAL
//   d     - data loaded on every rising edge while rst_n is high
//   q     - registered data
module d_ff_stage
  import d_flip_flop_pkg::*;
#(
  parameter int             WDT     = DFF_WDT_DEF,
  parameter logic [WDT-1:0] RST_VAL = WDT'(DFF_RST_VAL_DEF)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [WDT-1:0] d,
  output logic [WDT-1:0] q
);

  // Stage register: unconditional load each edge, async clear to RST_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule : d_ff_stage

// File: rtl/d_flip_flop.sv
// d_flip_flop: STAGES-deep cascade of WDT-wide registers; d_out is d_in
// delayed by exactly STAGES rising edges.
// Optional feature macro: D_FLIP_FLOP_CHG_FLAG_EN adds the d_chg output.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, every stage goes to RST_VAL
//   d_in  - data sampled into stage 0
//   d_out - output of the last stage, straight from its flop
//   d_chg - (D_FLIP_FLOP_CHG_FLAG_EN only) registered flag, high for the
//           cycle after an edge that changed d_out
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int             WDT     = DFF_WDT_DEF,
  parameter logic [WDT-1:0] RST_VAL = WDT'(DFF_RST_VAL_DEF),
  parameter int             STAGES  = DFF_STAGES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [WDT-1:0] d_in,
`ifdef D_FLIP_FLOP_CHG_FLAG_EN
  output logic [WDT-1:0] d_out,
  output logic           d_chg
`else
  output logic [WDT-1:0] d_out
`endif
);

  // Reject illegal configurations at elaboration.
  if (WDT < 1 || WDT > DFF_WDT_MAX) begin : g_bad_wdt
    $error("d_flip_flop: WDT=%0d outside 1..%0d", WDT, DFF_WDT_MAX);
  end
  if (STAGES < 1 || STAGES > DFF_STAGES_MAX) begin : g_bad_stages
    $error("d_flip_flop: STAGES=%0d outside 1..%0d", STAGES, DFF_STAGES_MAX);
  end

  logic [WDT-1:0] stage_q [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [WDT-1:0] stage_d;
    if (i == 0) begin : g_first
      assign stage_d = d_in;
    end else begin : g_chain
      assign stage_d = stage_q[i-1];
    end

    d_ff_stage #(
      .WDT     (WDT),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (stage_d),
      .q     (stage_q[i])
    );
  end

  // Last stage flop drives the output with nothing in between.
  assign d_out = stage_q[STAGES-1];

`ifdef D_FLIP_FLOP_CHG_FLAG_EN
  // Value the last stage will take at the coming edge.
  logic [WDT-1:0] next_out;
  if (STAGES == 1) begin : g_next_single
    assign next_out = d_in;
  end else begin : g_next_chain
    assign next_out = stage_q[STAGES-2];
  end

  // Change flag: compares upcoming and current d_out so the flag rises in
  // the same cycle d_out takes its new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_chg <= 1'b0;
    end else begin
      d_chg <= (next_out != d_out);
    end
  end
`endif

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: directed, table-driven checks of d_flip_flop in four
// configurations sharing one clock and reset:
//   a: defaults (WDT=1, STAGES=1, RST_VAL=0)
//   b: WDT=1, RST_VAL=1
//   c: WDT=8, STAGES=3, RST_VAL=0
//   e: WDT=4, STAGES=1 (d_chg checked when D_FLIP_FLOP_CHG_FLAG_EN is set)
module tb_d_flip_flop;

  logic       clk;
  logic       rst_n;
  logic       a_in,  a_out;
  logic       b_in,  b_out;
  logic [7:0] c_in,  c_out;
  logic [3:0] e_in,  e_out;
`ifdef D_FLIP_FLOP_CHG_FLAG_EN
  logic       a_chg, b_chg, c_chg, e_chg;
`endif

  int total = 0;
  int bad   = 0;

  d_flip_flop u_a (
    .clk(clk), .rst_n(rst_n), .d_in(a_in),
`ifdef D_FLIP_FLOP_CHG_FLAG_EN
    .d_chg(a_chg),
`endif
    .d_out(a_out)
  );

  d_flip_flop #(.WDT(1), .RST_VAL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .d_in(b_in),
`ifdef D_FLIP_FLOP_CHG_FLAG_EN
    .d_chg(b_chg),
`endif
    .d_out(b_out)
  );

  d_flip_flop #(.WDT(8), .RST_VAL(8'h00), .STAGES(3)) u_c (
    .clk(clk), .rst_n(rst_n), .d_in(c_in),
`ifdef D_FLIP_FLOP_CHG_FLAG_EN
    .d_chg(c_chg),
`endif
    .d_out(c_out)
  );

  d_flip_flop #(.WDT(4), .RST_VAL(4'h0), .STAGES(1)) u_e (
    .clk(clk), .rst_n(rst_n), .d_in(e_in),
`ifdef D_FLIP_FLOP_CHG_FLAG_EN
    .d_chg(e_chg),
`endif
    .d_out(e_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic       a_in;
    logic       a_exp;
    logic [7:0] c_in;
    logic [7:0] c_exp;
    logic [3:0] e_in;
    logic [3:0] e_exp;
    logic       e_chg;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // c_exp after edge k is c_in of edge k-2 (3-stage latency, pipe was 0).
    // e_chg is high when e_out changed at that edge.
    vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h00, 4'h5, 4'h5, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 8'h3C, 8'h00, 4'h5, 4'h5, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'hA5, 4'h5, 4'h5, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h3C, 4'h6, 4'h6, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 8'h00, 8'hFF, 4'h6, 4'h6, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h5A, 8'h00, 4'h0, 4'h0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 8'h81, 8'h00, 4'h0, 4'h0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h81, 8'h5A, 4'hF, 4'hF, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 8'h99, 8'h81, 4'hF, 4'hF, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 8'hC3, 8'h81, 4'hF, 4'hF, 1'b0};

    rst_n = 1'b1;
    a_in  = 1'b0;
    b_in  = 1'b0;
    c_in  = 8'h00;
    e_in  = 4'h0;

    // Before reset: b (RST_VAL=1) has loaded 0 at edges 5 and 15.
    #20;
    check("b_pre_reset", 32'(b_out), 32'h0);

    // Async reset at t=21, no edge until 25.
    #1 rst_n = 1'b0;
    #1;
    check("a_async_reset", 32'(a_out), 32'h0);
    check("b_async_reset", 32'(b_out), 32'h1);
    check("c_async_reset", 32'(c_out), 32'h00);

    // Edges at 25 and 35 are ignored while reset is held.
    a_in = 1'b1;
    b_in = 1'b0;
    #16;
    check("a_reset_hold", 32'(a_out), 32'h0);
    check("b_reset_hold", 32'(b_out), 32'h1);
`ifdef D_FLIP_FLOP_CHG_FLAG_EN
    check("e_chg_reset", 32'(e_chg), 32'h0);
`endif
    a_in = 1'b0;

    // Release at 41; d_in rises at 61, seen after the edge at 65.
    #3 rst_n = 1'b1;
    #20 a_in = 1'b1;
    #3;
    check("a_before_edge", 32'(a_out), 32'h0);
    check("b_after_release", 32'(b_out), 32'h0);
    #2;
    check("a_first_load", 32'(a_out), 32'h1);
    #10;
    check("a_stays_1", 32'(a_out), 32'h1);
    check("c_idle_zero", 32'(c_out), 32'h00);

    // Table: one rising edge per vector, check 1 time unit after it.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_in = vecs[i].a_in;
      b_in = vecs[i].a_in;
      c_in = vecs[i].c_in;
      e_in = vecs[i].e_in;
      @(posedge clk);
      #1;
      check($sformatf("a_vec%0d", i), 32'(a_out), 32'(vecs[i].a_exp));
      check($sformatf("b_vec%0d", i), 32'(b_out), 32'(vecs[i].a_exp));
      check($sformatf("c_vec%0d", i), 32'(c_out), 32'(vecs[i].c_exp));
      check($sformatf("e_vec%0d", i), 32'(e_out), 32'(vecs[i].e_exp));
`ifdef D_FLIP_FLOP_CHG_FLAG_EN
      check($sformatf("e_chg_vec%0d", i), 32'(e_chg), 32'(vecs[i].e_chg));
`endif
    end

    // Mid-pipeline reset: push 11, 22 behind 99, C3.
    @(negedge clk) c_in = 8'h11;
    @(posedge clk) #1;
    check("c_drain_99", 32'(c_out), 32'h99);
    @(negedge clk) c_in = 8'h22;
    @(posedge clk) #1;
    check("c_drain_c3", 32'(c_out), 32'hC3);
    #2 rst_n = 1'b0;
    #1;
    check("c_mid_reset", 32'(c_out), 32'h00);
    check("b_mid_reset", 32'(b_out), 32'h1);
    check("e_mid_reset", 32'(e_out), 32'h0);
    c_in = 8'h33;
    b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("c_reset_hold", 32'(c_out), 32'h00);

    // Release: 77 then 44 enter; no stale 11/22 may surface.
    @(negedge clk);
    c_in  = 8'h77;
    rst_n = 1'b1;
    @(posedge clk) #1;
    check("c_post_rel_1", 32'(c_out), 32'h00);
    check("b_post_rel_1", 32'(b_out), 32'h0);
    @(negedge clk) c_in = 8'h44;
    @(posedge clk) #1;
    check("c_post_rel_2", 32'(c_out), 32'h00);
    @(negedge clk) c_in = 8'h00;
    @(posedge clk) #1;
    check("c_post_rel_3", 32'(c_out), 32'h77);
    @(posedge clk) #1;
    check("c_post_rel_4", 32'(c_out), 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout at t=%0t: got running, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_d_flip_flop
